// File: rtl/conv1d_output_packer.sv
// Packs int8 conv results four-per-word little-endian into a show-ahead word FIFO; commit is visible
// the cycle after the accepting edge. in_ready drops while the FIFO is full; the CPU drains with rd_en_i.

module conv1d_packer_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign push       = wr_en_i && (count_q < FULL_CNT);
  assign pop        = rd_en_i && (count_q != '0);
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never visible past rd_valid_o.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

module conv1d_output_packer #(
  parameter int INT32_SIZE    = 32,
  parameter int BYTE_SIZE     = 8,
  parameter int FIFO_WORDS    = 16,
  parameter int MAX_OUT_DEPTH = 128
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               cfg_we_i,
  input  logic [$clog2(MAX_OUT_DEPTH):0]     cfg_depth_i,
  input  logic                               in_valid_i,
  input  logic [INT32_SIZE-1:0]              in_data_i,
  output logic                               in_ready_o,
  input  logic                               rd_en_i,
  output logic                               rd_valid_o,
  output logic [INT32_SIZE-1:0]              rd_data_o,
  output logic [$clog2(FIFO_WORDS):0]        count_o,
  output logic                               sat_flag_o
);
  localparam int LANES = INT32_SIZE / BYTE_SIZE;
  localparam int LW    = $clog2(LANES);
  localparam int DW    = $clog2(MAX_OUT_DEPTH) + 1;
  localparam int CW    = $clog2(FIFO_WORDS) + 1;
  localparam logic [CW-1:0] FULL_CNT = FIFO_WORDS[CW-1:0];

  logic [LW-1:0]         lane_q, lane_d;
  logic [DW-1:0]         chan_q, chan_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic [INT32_SIZE-1:0] pack_q, pack_d;
  logic                  sat_q, sat_d;
  logic [INT32_SIZE-1:0] word;
  logic                  accept, last_lane, last_chan, commit, out_of_range;
  logic [CW-1:0]         count;

  assign in_ready_o = !rst_i && (count < FULL_CNT);
  assign accept     = in_valid_i && in_ready_o && !cfg_we_i;
  assign last_lane  = (lane_q == LW'(LANES - 1));
  assign last_chan  = (chan_q == depth_q - DW'(1));
  assign commit     = accept && (last_lane || last_chan);
  // In range only when every bit from the int8 sign bit upward agrees.
  assign out_of_range = !((&in_data_i[INT32_SIZE-1:BYTE_SIZE-1]) ||
                          (~|in_data_i[INT32_SIZE-1:BYTE_SIZE-1]));
  assign sat_flag_o = sat_q;
  assign count_o    = count;

  always_comb begin
    word = '0;
    for (int l = 0; l < LANES; l++) begin
      if (l < int'(lane_q))
        word[l*BYTE_SIZE +: BYTE_SIZE] = pack_q[l*BYTE_SIZE +: BYTE_SIZE];
      else if (l == int'(lane_q))
        word[l*BYTE_SIZE +: BYTE_SIZE] = in_data_i[BYTE_SIZE-1:0];
    end
  end

  always_comb begin
    lane_d  = lane_q;
    chan_d  = chan_q;
    pack_d  = pack_q;
    depth_d = depth_q;
    sat_d   = sat_q;
    if (cfg_we_i) begin
      depth_d = (cfg_depth_i == '0) ? DW'(1) : cfg_depth_i;
      lane_d  = '0;
      chan_d  = '0;
      pack_d  = '0;
      sat_d   = 1'b0;
    end else if (accept) begin
      if (out_of_range) sat_d = 1'b1;
      chan_d = last_chan ? '0 : chan_q + DW'(1);
      if (commit) begin
        lane_d = '0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + LW'(1);
        pack_d = word;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q  <= '0;
      chan_q  <= '0;
      pack_q  <= '0;
      depth_q <= DW'(1);
      sat_q   <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      chan_q  <= chan_d;
      pack_q  <= pack_d;
      depth_q <= depth_d;
      sat_q   <= sat_d;
    end
  end

  conv1d_packer_fifo #(
    .WIDTH (INT32_SIZE),
    .DEPTH (FIFO_WORDS)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (commit),
    .wr_data_i  (word),
    .rd_en_i    (rd_en_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .count_o    (count)
  );
endmodule

// File: tb/tb_conv1d_output_packer.sv
// Bench for conv1d_output_packer: queue-based packing model compared every cycle, plus literal word checks.
module tb_conv1d_output_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_depth = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        rd_en = 1'b0;
  logic        in_ready, rd_valid, sat_flag;
  logic [31:0] rd_data;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv1d_output_packer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_depth_i (cfg_depth),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .rd_en_i     (rd_en),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data),
    .count_o     (count),
    .sat_flag_o  (sat_flag)
  );

  // Model: list of finished words plus the bytes gathered for the current position.
  logic [31:0] m_q[$];
  logic [31:0] m_cur = '0;
  int  m_nb = 0, m_chan = 0, m_depth = 1;
  bit  m_sat = 0, m_acc = 0, chk_en = 0, t4_on = 0;
  int  dut_pops = 0, max_cnt = 0;

  function automatic bit m_ready();
    return !rst && (m_q.size() < 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit do_pop, do_acc;
    m_acc = 0;
    if (rst) begin
      m_q.delete();
      m_cur = '0; m_nb = 0; m_chan = 0; m_depth = 1; m_sat = 0;
    end else begin
      do_pop = rd_en && (m_q.size() > 0);
      do_acc = in_valid && (m_q.size() < 16) && !cfg_we;
      if (do_pop) void'(m_q.pop_front());
      if (cfg_we) begin
        m_depth = (cfg_depth == 0) ? 1 : int'(cfg_depth);
        m_cur = '0; m_nb = 0; m_chan = 0; m_sat = 0;
      end else if (do_acc) begin
        m_acc = 1;
        if ($signed(in_data) > 127 || $signed(in_data) < -128) m_sat = 1;
        m_cur[m_nb*8 +: 8] = in_data[7:0];
        m_nb++;
        if (m_nb == 4 || m_chan == m_depth - 1) begin
          m_q.push_back(m_cur);
          m_cur = '0;
          m_nb = 0;
        end
        m_chan = (m_chan == m_depth - 1) ? 0 : m_chan + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_ready());
      chk("rd_valid", rd_valid, m_q.size() > 0);
      chk("rd_data", rd_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
      chk("count", count, m_q.size());
      chk("sat_flag", sat_flag, m_sat);
      if (rd_en && rd_valid) dut_pops++;
      if (t4_on && int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 200);
    if (!m_acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data=%h not accepted in 200 cycles", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic cfg(input int d);
    cfg_we = 1'b1;
    cfg_depth = 8'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_q.size() > 0 && n < 100) begin
      pop();
      n++;
    end
    chk("drain_empty", count, 0);
  endtask

  initial begin
    int t2[6];
    int p0;
    logic [31:0] exp;
    t2 = '{-1, -2, -3, -4, 5, 6};

    rst = 1'b1;
    tick();
    chk_en = 1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_data", rd_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: two full words
    cfg(8);
    for (int i = 1; i <= 8; i++) send(32'(i));
    chk("t1_count", count, 2);
    chk("t1_model_w0", m_q[0], 32'h04030201);
    chk("t1_w0", rd_data, 32'h04030201);
    chk("t1_sat", sat_flag, 0);
    pop();
    chk("t1_w1", rd_data, 32'h08070605);
    pop();

    // 2: negative values and a zero-padded partial word
    cfg(6);
    for (int i = 0; i < 6; i++) send(32'(t2[i]));
    chk("t2_model_w0", m_q[0], 32'hFCFDFEFF);
    chk("t2_w0", rd_data, 32'hFCFDFEFF);
    pop();
    chk("t2_model_w1", m_q[0], 32'h00000605);
    chk("t2_w1", rd_data, 32'h00000605);
    pop();

    // 3: fill to full, single pop, pointer wrap
    cfg(4);
    for (int i = 0; i < 64; i++) send(32'(i + 1));
    chk("t3_full_count", count, 16);
    chk("t3_full_ready", in_ready, 0);
    pop();
    chk("t3_ready_after_pop", in_ready, 1);
    chk("t3_count_after_pop", count, 15);
    for (int i = 65; i <= 68; i++) send(32'(i));
    for (int k = 1; k <= 16; k++) begin
      exp = {8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)};
      chk("t3_order", rd_data, exp);
      pop();
    end
    chk("t3_empty", rd_valid, 0);

    // 4: stream 1 byte/cycle, pop 1 word/4 cycles
    cfg(4);
    p0 = dut_pops;
    max_cnt = 0;
    t4_on = 1;
    fork
      for (int i = 0; i < 400; i++) send(32'(i % 100));
      repeat (100) begin
        repeat (3) tick();
        pop();
      end
    join
    t4_on = 0;
    checks++;
    if (max_cnt > 2) begin
      errors++;
      $display("FAIL t4_count_stable actual=%0d required<=2", max_cnt);
    end
    drain();
    chk("t4_words", 32'(dut_pops - p0), 100);

    // 5: saturation flag and low-byte packing
    cfg(2);
    send(32'd200);
    send(32'hFFFF_FF7F);
    chk("t5_word", rd_data, 32'h00007FC8);
    chk("t5_sat", sat_flag, 1);
    chk("t5_count", count, 1);
    cfg(3);
    chk("t5_sat_cleared", sat_flag, 0);
    chk("t5_fifo_kept_count", count, 1);
    chk("t5_fifo_kept_word", rd_data, 32'h00007FC8);
    drain();

    // 6: reset mid-packing with queued words
    cfg(4);
    for (int i = 1; i <= 14; i++) send(32'(i));
    chk("t6_pre_count", count, 3);
    rst = 1'b1;
    tick();
    chk("t6_rst_count", count, 0);
    chk("t6_rst_valid", rd_valid, 0);
    chk("t6_rst_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    cfg(4);
    for (int i = 10; i <= 13; i++) send(32'(i));
    chk("t6_one_word", count, 1);
    chk("t6_clean_word", rd_data, 32'h0D0C0B0A);
    pop();
    chk("t6_empty", count, 0);

    tick();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
